// File: rtl/cache_pkg.sv
// Shared types and geometry for the byte write-merge buffer.
package cache_pkg;
    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 8;
    localparam int OFFSET_W   = 3;
    localparam int TAG_W      = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, MERGE, DRAIN} wm_state_t;
    typedef logic [TAG_W-1:0] tag_t;

    function automatic tag_t addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_W];
    endfunction
endpackage

// File: rtl/byte_write_merge_if.sv
// CPU byte-store port and merged-line port of the write-merge buffer.
interface byte_write_merge_if;
    import cache_pkg::*;

    logic                  caWVALID;
    logic                  caWREADY;
    logic [ADDR_W-1:0]     caWADDR;
    logic [7:0]            caWDATA;
    logic                  flush;
    logic                  lnVALID;
    logic                  lnREADY;
    tag_t                  lnTAG;
    logic [LINE_BYTES*8-1:0] lnDATA;
    logic [LINE_BYTES-1:0] lnSTRB;
    logic                  busy;

    modport slave (
        input  caWVALID, caWADDR, caWDATA, flush, lnREADY,
        output caWREADY, lnVALID, lnTAG, lnDATA, lnSTRB, busy
    );

    modport master (
        output caWVALID, caWADDR, caWDATA, flush, lnREADY,
        input  caWREADY, lnVALID, lnTAG, lnDATA, lnSTRB, busy
    );
endinterface

// File: rtl/byte_lane_decoder.sv
// Byte offset to one-hot lane enable; shared by the data and mask writes.
module byte_lane_decoder
    import cache_pkg::*;
(
    input  logic [OFFSET_W-1:0]   offset,
    output logic [LINE_BYTES-1:0] lane
);
    always_comb begin
        lane = LINE_BYTES'(1) << offset;
    end
endmodule

// File: rtl/byte_write_merge.sv
// Merges single-byte stores into one 64-bit line and hands it out with byte strobes.
module byte_write_merge
    import cache_pkg::*;
(
    input  logic ACLK,
    input  logic ARESETn,
    byte_write_merge_if.slave bus
);
    wm_state_t               state;
    wm_state_t               state_nxt;
    tag_t                    tag_r;
    logic [LINE_BYTES*8-1:0] line_buf;
    logic [LINE_BYTES-1:0]   mask;
    logic [LINE_BYTES-1:0]   lane;
    logic [LINE_BYTES-1:0]   mask_merged;
    logic                    addr_hit;
    logic                    ready;
    logic                    accept;

    byte_lane_decoder u_lane_dec (
        .offset (bus.caWADDR[OFFSET_W-1:0]),
        .lane   (lane)
    );

    always_comb begin
        addr_hit    = (addr_tag(bus.caWADDR) == tag_r);
        mask_merged = mask | lane;
        ready       = 1'b0;
        state_nxt   = state;
        case (state)
            IDLE:    ready = 1'b1;
            MERGE:   ready = addr_hit;
            default: ready = 1'b0;
        endcase
        accept = bus.caWVALID & ready;
        case (state)
            IDLE: begin
                if (accept) state_nxt = MERGE;
            end
            MERGE: begin
                // A same-tag byte in the flush cycle is merged before the drain.
                if (bus.flush || (bus.caWVALID && !addr_hit) ||
                    (accept && (mask_merged == '1)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (bus.lnREADY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= IDLE;
            tag_r    <= '0;
            mask     <= '0;
            line_buf <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                for (int k = 0; k < LINE_BYTES; k++) begin
                    if (lane[k]) line_buf[8*k +: 8] <= bus.caWDATA;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        tag_r <= addr_tag(bus.caWADDR);
                        mask  <= lane;
                    end
                end
                MERGE: begin
                    if (accept) mask <= mask_merged;
                end
                DRAIN: begin
                    if (bus.lnREADY) mask <= '0;
                end
                default: mask <= '0;
            endcase
        end
    end

    assign bus.caWREADY = ready;
    assign bus.lnVALID  = (state == DRAIN);
    assign bus.busy     = (state != IDLE);
    assign bus.lnSTRB   = (state == DRAIN) ? mask : '0;
    assign bus.lnDATA   = line_buf;
    assign bus.lnTAG    = tag_r;
endmodule

// File: tb/tb_byte_write_merge.sv
// Directed bench for byte_write_merge with a per-cycle line-level reference model.
module tb_byte_write_merge;
    import cache_pkg::*;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    byte_write_merge_if bus ();

    byte_write_merge dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference model: an open line (tag + per-byte contents) and a pending outgoing line.
    bit          m_open;
    tag_t        m_tag;
    logic [7:0]  m_byte [8];
    bit          m_bv   [8];
    bit          m_pend;
    tag_t        m_ptag;
    logic [63:0] m_pdata;
    logic [7:0]  m_pstrb;

    always @(negedge ACLK) begin : model
        bit          hit;
        bit          exp_rdy;
        bit          acc;
        bit          full;
        logic [63:0] bmask;
        if (!ARESETn) begin
            m_open = 0;
            m_pend = 0;
            check("rst_lnVALID", 64'(bus.lnVALID), 64'd0);
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_caWREADY", 64'(bus.caWREADY), 64'd1);
            check("rst_lnSTRB", 64'(bus.lnSTRB), 64'd0);
        end else begin
            hit     = m_open && (bus.caWADDR[31:3] == m_tag);
            exp_rdy = !m_pend && (!m_open || hit);
            check("mdl_caWREADY", 64'(bus.caWREADY), 64'(exp_rdy));
            check("mdl_lnVALID", 64'(bus.lnVALID), 64'(m_pend));
            check("mdl_busy", 64'(bus.busy), 64'(m_open || m_pend));
            if (m_pend) begin
                for (int k = 0; k < 8; k++) bmask[8*k +: 8] = {8{m_pstrb[k]}};
                check("mdl_lnSTRB", 64'(bus.lnSTRB), 64'(m_pstrb));
                check("mdl_lnTAG", 64'(bus.lnTAG), 64'(m_ptag));
                check("mdl_lnDATA", bus.lnDATA & bmask, m_pdata & bmask);
            end
            acc = bus.caWVALID && exp_rdy;
            if (m_pend) begin
                if (bus.lnREADY) m_pend = 0;
            end else if (!m_open) begin
                if (acc) begin
                    m_open = 1;
                    m_tag  = bus.caWADDR[31:3];
                    for (int k = 0; k < 8; k++) begin
                        m_bv[k]   = 0;
                        m_byte[k] = 8'h00;
                    end
                    m_bv[bus.caWADDR[2:0]]   = 1;
                    m_byte[bus.caWADDR[2:0]] = bus.caWDATA;
                end
            end else begin
                if (acc) begin
                    m_bv[bus.caWADDR[2:0]]   = 1;
                    m_byte[bus.caWADDR[2:0]] = bus.caWDATA;
                end
                full = 1;
                for (int k = 0; k < 8; k++) if (!m_bv[k]) full = 0;
                if ((acc && full) || bus.flush || (bus.caWVALID && !hit)) begin
                    m_pend = 1;
                    m_open = 0;
                    m_ptag = m_tag;
                    for (int k = 0; k < 8; k++) begin
                        m_pstrb[k]        = m_bv[k];
                        m_pdata[8*k +: 8] = m_byte[k];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic put(input logic [31:0] addr, input logic [7:0] data);
        bus.caWVALID = 1'b1;
        bus.caWADDR  = addr;
        bus.caWDATA  = data;
        step();
    endtask

    task automatic drain();
        bus.lnREADY = 1'b1;
        step();
        bus.lnREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.caWVALID = 1'b0;
        bus.caWADDR  = '0;
        bus.caWDATA  = '0;
        bus.flush    = 1'b0;
        bus.lnREADY  = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_lnDATA", bus.lnDATA, 64'd0);
        check("reset_lnTAG", 64'(bus.lnTAG), 64'd0);
        check("reset_caWREADY", 64'(bus.caWREADY), 64'd1);
        ARESETn = 1'b1;
        step();

        // Full line of back-to-back bytes drains on its own.
        for (int i = 0; i < 8; i++) put(32'h100 + 32'(i), 8'(8'hA0 + i));
        bus.caWVALID = 1'b0;
        check("t1_lnVALID", 64'(bus.lnVALID), 64'd1);
        check("t1_lnTAG", 64'(bus.lnTAG), 64'h20);
        check("t1_lnDATA", bus.lnDATA, 64'hA7A6A5A4A3A2A1A0);
        check("t1_lnSTRB", 64'(bus.lnSTRB), 64'hFF);
        check("t1_caWREADY", 64'(bus.caWREADY), 64'd0);
        drain();
        check("t1_idle_busy", 64'(bus.busy), 64'd0);

        // Single byte then flush.
        put(32'h203, 8'h5A);
        bus.caWVALID = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        check("t2_lnVALID", 64'(bus.lnVALID), 64'd1);
        check("t2_byte3", 64'(bus.lnDATA[31:24]), 64'h5A);
        check("t2_lnSTRB", 64'(bus.lnSTRB), 64'h08);
        check("t2_lnTAG", 64'(bus.lnTAG), 64'h40);
        drain();

        // Tag mismatch stalls the new byte until the old line leaves.
        put(32'h300, 8'h11);
        bus.caWADDR = 32'h308;
        bus.caWDATA = 8'h22;
        #1;
        check("t3_mismatch_rdy", 64'(bus.caWREADY), 64'd0);
        step();
        check("t3_lnVALID", 64'(bus.lnVALID), 64'd1);
        check("t3_lnSTRB", 64'(bus.lnSTRB), 64'h01);
        check("t3_lnTAG", 64'(bus.lnTAG), 64'h60);
        check("t3_byte0", 64'(bus.lnDATA[7:0]), 64'h11);
        drain();
        check("t3_idle_rdy", 64'(bus.caWREADY), 64'd1);
        step();
        bus.caWVALID = 1'b0;
        check("t3_busy_new", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t3_new_tag", 64'(bus.lnTAG), 64'h61);
        check("t3_new_strb", 64'(bus.lnSTRB), 64'h01);
        check("t3_new_byte0", 64'(bus.lnDATA[7:0]), 64'h22);
        drain();

        // Last write wins; outputs hold while the consumer stalls.
        put(32'h401, 8'h33);
        put(32'h401, 8'h44);
        bus.caWVALID = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.caWVALID = 1'b1;
        bus.caWADDR  = 32'h401;
        bus.caWDATA  = 8'h55;
        for (int c = 0; c < 5; c++) begin
            check("t4_lnVALID", 64'(bus.lnVALID), 64'd1);
            check("t4_byte1", 64'(bus.lnDATA[15:8]), 64'h44);
            check("t4_lnSTRB", 64'(bus.lnSTRB), 64'h02);
            check("t4_lnTAG", 64'(bus.lnTAG), 64'h80);
            check("t4_caWREADY", 64'(bus.caWREADY), 64'd0);
            step();
        end
        bus.caWVALID = 1'b0;
        drain();
        check("t4_busy_after", 64'(bus.busy), 64'd0);

        // Same-tag write coinciding with flush is merged into the line.
        put(32'h500, 8'h99);
        bus.caWADDR = 32'h502;
        bus.caWDATA = 8'h77;
        bus.flush   = 1'b1;
        step();
        bus.caWVALID = 1'b0;
        bus.flush    = 1'b0;
        check("t5_lnSTRB", 64'(bus.lnSTRB), 64'h05);
        check("t5_byte2", 64'(bus.lnDATA[23:16]), 64'h77);
        check("t5_byte0", 64'(bus.lnDATA[7:0]), 64'h99);
        check("t5_lnTAG", 64'(bus.lnTAG), 64'hA0);
        drain();

        // Reset during drain drops the line at once; later flush finds nothing.
        put(32'h600, 8'h12);
        bus.caWVALID = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        check("t6_lnVALID_pre", 64'(bus.lnVALID), 64'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        check("t6_lnVALID_rst", 64'(bus.lnVALID), 64'd0);
        check("t6_busy_rst", 64'(bus.busy), 64'd0);
        step();
        step();
        ARESETn   = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        check("t6_lnVALID_post", 64'(bus.lnVALID), 64'd0);
        check("t6_busy_post", 64'(bus.busy), 64'd0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
